// File: rtl/mdu_unit.sv
// Multiply/divide unit for the E stage: runs mult/div commands over a fixed number of Busy cycles and owns HI/LO.
// Optional macro MDU_MADD_EN adds madd (MU_op 9) and maddu (MU_op 10).
module mdu_unit #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [3:0]  MU_op,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MU_RES
);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
`endif

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  logic [31:0]   hi_reg, lo_reg;
  logic [31:0]   pend_hi_reg, pend_lo_reg;
  logic          pend_wr_reg;
  logic          busy_reg;
  logic [CW-1:0] cnt_reg;

  logic [31:0]   pend_hi_next, pend_lo_next;
  logic          pend_wr_next;
  logic [CW-1:0] cnt_next;
  logic          accept;
  logic          idle_ok;

  // Products: sign-extending to 64 bits makes the low 64 bits of the product the signed result.
  logic [63:0] a_sx, b_sx, smul, umul;
  assign a_sx = {{32{A[31]}}, A};
  assign b_sx = {{32{B[31]}}, B};
  assign smul = a_sx * b_sx;
  assign umul = {32'd0, A} * {32'd0, B};

  // Signed division done on magnitudes so the most-negative dividend has a defined result.
  logic [31:0] a_mag, b_mag, mag_q, mag_r, sdiv_q, sdiv_r, udiv_q, udiv_r;
  logic        b_zero;
  assign b_zero = (B == 32'd0);
  assign a_mag  = A[31] ? (~A + 32'd1) : A;
  assign b_mag  = B[31] ? (~B + 32'd1) : B;
  assign mag_q  = b_zero ? 32'd0 : (a_mag / b_mag);
  assign mag_r  = b_zero ? 32'd0 : (a_mag % b_mag);
  assign sdiv_q = (A[31] ^ B[31]) ? (~mag_q + 32'd1) : mag_q;
  assign sdiv_r = A[31] ? (~mag_r + 32'd1) : mag_r;
  assign udiv_q = b_zero ? 32'd0 : (A / B);
  assign udiv_r = b_zero ? 32'd0 : (A % B);

`ifdef MDU_MADD_EN
  logic [63:0] madd_sum, maddu_sum;
  assign madd_sum  = {hi_reg, lo_reg} + smul;
  assign maddu_sum = {hi_reg, lo_reg} + umul;
`endif

  assign idle_ok = !Req && !busy_reg;

  always_comb begin
    accept       = 1'b0;
    pend_hi_next = 32'd0;
    pend_lo_next = 32'd0;
    pend_wr_next = 1'b1;
    cnt_next     = CW'(MULT_CYC);
    case (MU_op)
      OP_MULT: begin
        accept = Start && idle_ok;
        {pend_hi_next, pend_lo_next} = smul;
      end
      OP_MULTU: begin
        accept = Start && idle_ok;
        {pend_hi_next, pend_lo_next} = umul;
      end
      OP_DIV: begin
        accept       = Start && idle_ok;
        pend_hi_next = sdiv_r;
        pend_lo_next = sdiv_q;
        pend_wr_next = !b_zero;
        cnt_next     = CW'(DIV_CYC);
      end
      OP_DIVU: begin
        accept       = Start && idle_ok;
        pend_hi_next = udiv_r;
        pend_lo_next = udiv_q;
        pend_wr_next = !b_zero;
        cnt_next     = CW'(DIV_CYC);
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        accept = Start && idle_ok;
        {pend_hi_next, pend_lo_next} = madd_sum;
      end
      OP_MADDU: begin
        accept = Start && idle_ok;
        {pend_hi_next, pend_lo_next} = maddu_sum;
      end
`endif
      default: accept = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      pend_hi_reg <= 32'd0;
      pend_lo_reg <= 32'd0;
      pend_wr_reg <= 1'b0;
      busy_reg    <= 1'b0;
      cnt_reg     <= '0;
    end else if (busy_reg) begin
      if (cnt_reg == CW'(1)) begin
        busy_reg <= 1'b0;
        cnt_reg  <= '0;
        if (pend_wr_reg) begin
          hi_reg <= pend_hi_reg;
          lo_reg <= pend_lo_reg;
        end
      end else begin
        cnt_reg <= cnt_reg - CW'(1);
      end
    end else if (accept) begin
      busy_reg    <= 1'b1;
      cnt_reg     <= cnt_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
      pend_wr_reg <= pend_wr_next;
    end else if (!Req && MU_op == OP_MTHI) begin
      hi_reg <= A;
    end else if (!Req && MU_op == OP_MTLO) begin
      lo_reg <= A;
    end
  end

  assign Busy   = busy_reg;
  assign HI     = hi_reg;
  assign LO     = lo_reg;
  assign MU_RES = (MU_op == OP_MFHI) ? hi_reg :
                  (MU_op == OP_MFLO) ? lo_reg : 32'd0;

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: vector table plus random vectors through a result queue, then hand-written corner sequences.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [3:0]  MU_op = 4'd8;
  logic        Req = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] HI, LO, MU_RES;

  int total = 0;
  int bad = 0;

  mdu_unit #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .MU_op(MU_op), .Req(Req),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO), .MU_RES(MU_RES)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    int          cyc;
    string       tag;
  } exp_t;

  vec_t vecs[12];
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  task automatic mov(input logic [3:0] op, input logic [31:0] val, input logic rq);
    @(negedge clk);
    MU_op = op; A = val; Req = rq; Start = 1'b0;
    @(negedge clk);
    MU_op = 4'd8; Req = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1; MU_op = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; MU_op = 4'd8;
  endtask

  // Counts Busy cycles (sampled at negedges), then pops the expected result and compares.
  task automatic wait_done();
    int n;
    exp_t e;
    n = 0;
    while (Busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: result with empty queue");
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_busy"}, 32'(n), 32'(e.cyc));
      check({e.tag, "_hi"}, HI, e.hi);
      check({e.tag, "_lo"}, LO, e.lo);
      $display("op %s: busy=%0d HI=%08h LO=%08h", e.tag, n, HI, LO);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    mov(4'd4, v.pre_hi, 1'b0);
    mov(4'd5, v.pre_lo, 1'b0);
    e.hi = v.exp_hi; e.lo = v.exp_lo; e.cyc = v.cyc; e.tag = tag;
    sb_q.push_back(e);
    issue(v.op, v.a, v.b);
    wait_done();
  endtask

  initial begin
    vecs[0]  = '{4'd0, 32'h00000003, 32'hFFFFFFFE, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{4'd2, 32'hFFFFFFF9, 32'h00000002, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 32'h0, 32'h0, 32'h00000001, 32'h7FFFFFFC, 10};
    vecs[3]  = '{4'd3, 32'h00000007, 32'h00000000, 32'h12345678, 32'h0BADF00D, 32'h12345678, 32'h0BADF00D, 10};
    vecs[4]  = '{4'd2, 32'h00000005, 32'h00000000, 32'hCAFEBABE, 32'h01020304, 32'hCAFEBABE, 32'h01020304, 10};
    vecs[5]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[6]  = '{4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h5, 32'h00000000, 32'h00000001, 5};
    vecs[7]  = '{4'd0, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 32'h00000000, 5};
    vecs[8]  = '{4'd2, 32'h00000007, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[9]  = '{4'd1, 32'h00010000, 32'h00010000, 32'h0, 32'h0, 32'h00000001, 32'h00000000, 5};
    vecs[10] = '{4'd3, 32'd100, 32'd7, 32'h0, 32'h0, 32'h00000002, 32'h0000000E, 10};
    vecs[11] = '{4'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h00000003, 10};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    MU_op = 4'd6; #1;
    check("rst_mures", MU_RES, 32'd0);
    MU_op = 4'd8;

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        MU_op = 4'd6; #1;
        check("mfhi_mures", MU_RES, 32'hFFFFFFFF);
        MU_op = 4'd7; #1;
        check("mflo_mures", MU_RES, 32'hFFFFFFFA);
        MU_op = 4'd8; #1;
        check("none_mures", MU_RES, 32'd0);
      end
    end

    // Random vectors against a reference built on native SV arithmetic
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      int sa, sb;
      longint sp;
      logic [63:0] up;
      v.op = 4'(i % 4);
      v.a = $urandom; v.b = $urandom;
      if (i >= 4 && v.b[3:0] == 4'd0) v.b = {v.b[31:4], 4'd3};
      if (v.b == 32'd0) v.b = 32'd1;
      v.pre_hi = 32'h0; v.pre_lo = 32'h0;
      sa = $signed(v.a); sb = $signed(v.b);
      case (i % 4)
        0: begin sp = longint'(sa) * longint'(sb); v.exp_hi = sp[63:32]; v.exp_lo = sp[31:0]; v.cyc = 5; end
        1: begin up = {32'd0, v.a} * {32'd0, v.b}; v.exp_hi = up[63:32]; v.exp_lo = up[31:0]; v.cyc = 5; end
        2: begin
          if (v.a == 32'h80000000 && v.b == 32'hFFFFFFFF) begin v.b = 32'd2; sb = 2; end
          v.exp_lo = 32'(sa / sb); v.exp_hi = 32'(sa % sb); v.cyc = 10;
        end
        default: begin v.exp_lo = v.a / v.b; v.exp_hi = v.a % v.b; v.cyc = 10; end
      endcase
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // Req blocks mtlo, mthi and Start
    mov(4'd5, 32'h00001111, 1'b0);
    mov(4'd4, 32'h00002222, 1'b0);
    mov(4'd5, 32'hAAAA5555, 1'b1);
    check("req_mtlo", LO, 32'h00001111);
    mov(4'd4, 32'hAAAA5555, 1'b1);
    check("req_mthi", HI, 32'h00002222);
    @(negedge clk);
    Start = 1'b1; MU_op = 4'd0; A = 32'd3; B = 32'd5; Req = 1'b1;
    @(negedge clk);
    Start = 1'b0; MU_op = 4'd8; Req = 1'b0;
    check("req_start_busy", 32'(Busy), 32'd0);
    $display("op req_block: HI=%08h LO=%08h busy=%0d", HI, LO, Busy);

    // Start div and mtlo during mult Busy are ignored
    begin
      int n;
      mov(4'd4, 32'h0, 1'b0);
      mov(4'd5, 32'h0, 1'b0);
      issue(4'd0, 32'd3, 32'd5);
      n = 0;
      while (Busy && n < 200) begin
        n++;
        if (n == 2) begin Start = 1'b1; MU_op = 4'd2; A = 32'd100; B = 32'd3; end
        else if (n == 3) begin Start = 1'b0; MU_op = 4'd5; A = 32'hDEAD; end
        else begin Start = 1'b0; MU_op = 4'd8; end
        @(negedge clk);
      end
      Start = 1'b0; MU_op = 4'd8;
      check("busy_ign_cycles", 32'(n), 32'd5);
      check("busy_ign_hi", HI, 32'd0);
      check("busy_ign_lo", LO, 32'd15);
      repeat (12) @(negedge clk);
      check("busy_ign_idle", 32'(Busy), 32'd0);
      check("busy_ign_lo_late", LO, 32'd15);
      $display("op busy_ignore: busy=%0d HI=%08h LO=%08h", n, HI, LO);
    end

    // Async reset mid-mult discards in-flight work
    mov(4'd4, 32'h5555, 1'b0);
    mov(4'd5, 32'h6666, 1'b0);
    issue(4'd1, 32'h00010000, 32'h00010000);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(Busy), 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("arst_late_busy", 32'(Busy), 32'd0);
    check("arst_late_hi", HI, 32'd0);
    check("arst_late_lo", LO, 32'd0);
    $display("op async_reset: HI=%08h LO=%08h busy=%0d", HI, LO, Busy);

    // madd / maddu
    mov(4'd4, 32'h0, 1'b0);
    mov(4'd5, 32'hFFFFFFFF, 1'b0);
`ifdef MDU_MADD_EN
    begin
      exp_t e;
      e.hi = 32'h1; e.lo = 32'h0; e.cyc = 5; e.tag = "madd";
      sb_q.push_back(e);
      issue(4'd9, 32'd1, 32'd1);
      wait_done();
      e.hi = 32'h2; e.lo = 32'hFFFFFFFE; e.cyc = 5; e.tag = "maddu";
      sb_q.push_back(e);
      issue(4'd10, 32'hFFFFFFFF, 32'd2);
      wait_done();
    end
`else
    issue(4'd9, 32'd1, 32'd1);
    check("madd_off_busy", 32'(Busy), 32'd0);
    repeat (6) @(negedge clk);
    check("madd_off_hi", HI, 32'h0);
    check("madd_off_lo", LO, 32'hFFFFFFFF);
    $display("op madd_disabled: HI=%08h LO=%08h busy=%0d", HI, LO, Busy);
`endif

    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the P7 pipeline.
- Executes the MU_op/Start commands issued by the instruction decoder (mult, multu, div, divu, mthi, mtlo, mfhi, mflo).
- Holds the HI/LO registers and drives Busy to the hazard/stall unit.
- Sources MU_RES for the GRF write-back mux (WDsel MU_RES).

Parameters:
MULT_CYC, 5, Busy cycles for mult/multu (>=1)
DIV_CYC, 10, Busy cycles for div/divu (>=1)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
Start  input  1  decoder start strobe (mult/multu/div/divu in E)
MU_op  input  4  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo, 8 none
Req  input  1  exception/interrupt flush; blocks any HI/LO-affecting command this cycle
A  input  32  forwarded rs value
B  input  32  forwarded rt value
Busy  output  1  operation in flight
HI  output  32  HI register
LO  output  32  LO register
MU_RES  output  32  mfhi→HI, mflo→LO, else 0 (combinational)

Behaviour:
- Reset (reset_n=0, async): HI=0, LO=0, Busy=0, cycle counter=0, pending result regs=0. All in-flight work is discarded.
- Accept condition at a rising edge T: Start=1 && MU_op in {0..3} && Req=0 && Busy=0.
  - On accept, capture the result into pending regs.
  - Load counter with MULT_CYC or DIV_CYC.
  - Busy=1 after edge T.
- Counter decrements every edge while Busy=1.
- At the edge where counter==1:
  - HI/LO take the pending values.
  - Busy falls.
  - Busy is therefore high for exactly N cycles; new HI/LO are visible after edge T+N.
- mult: {HI,LO} = signed(A)*signed(B), 64-bit.
- multu: {HI,LO} = unsigned 64-bit product.
- div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero (B==0, div or divu): operation still occupies DIV_CYC Busy cycles; HI/LO are left unchanged at completion.
- mthi/mtlo:
  - Single-cycle write of A to HI/LO at the edge.
  - Only when Req=0 and Busy=0; otherwise ignored.
  - Busy is not asserted.
- Start while Busy=1 is ignored (the stall unit prevents it; this is the defined fallback).
- Req=1 does not abort an in-flight operation. It only blocks new Start, mthi and mtlo in the same cycle.
- MU_RES:
  - Reflects current HI/LO combinationally.
  - During Busy it returns the old values (the stall unit holds mfhi/mflo while Busy or Start).
- MU_op values 9-15 behave as none.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - MU_op 9 = madd: {HI,LO} += signed(A)*signed(B), 64-bit wraparound.
  - MU_op 10 = maddu: unsigned equivalent.
  - Both require Start=1 and follow the same accept rule.
  - Latency MULT_CYC.
  - Accumulation base is HI/LO sampled at the accept edge.
- Undefined: MU_op 9/10 are treated as none (no Busy, no change).

Test Plan:
- Reset, then Start mult with A=3, B=0xFFFFFFFE (-2) → Busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; mfhi MU_RES=0xFFFFFFFF.
- Start div with A=0xFFFFFFF9 (-7), B=2 → Busy=1 for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Start divu with the same operands → LO=0x7FFFFFFC, HI=0x00000001.
- mthi A=0x12345678, then divu A=7, B=0 → Busy for 10 cycles; HI stays 0x12345678, LO unchanged.
- mtlo A=0xAAAA5555 with Req=1 → LO unchanged. Start mult with Req=1 → Busy stays 0. mult accepted, then Start div on cycle 2 of Busy → ignored; mult result lands at T+5.
- mult 0x10000*0x10000 started, reset_n pulled low at cycle 3 → Busy, HI and LO are 0 immediately (async); no late HI/LO update after release.
- (MDU_MADD_EN) HI=0, LO=0xFFFFFFFF, madd A=1, B=1 → after 5 cycles HI=1, LO=0. Without the macro, the same command → no Busy, no change.
